// File: rtl/decoded_msg_uart_if.sv
// Read port of the decoded-message RAM: the UART block masters the address and
// strobe, and the RAM returns data two cycles after the address is presented.
interface decoded_msg_uart_if;
    logic [4:0] ram_address;
    logic       ram_rden;
    logic [7:0] ram_q;

    modport master (output ram_address, output ram_rden, input ram_q);
    modport slave  (input ram_address, input ram_rden, output ram_q);
endinterface

// File: rtl/decoded_msg_uart.sv
// Sends the decoded message over an 8N1 UART line, followed by CR LF, whenever success rises.
// Define KEY_HEADER_EN to prefix the message with "K<six hex key digits>:".
module decoded_msg_uart #(
    parameter int CLKS_PER_BIT = 434,
    parameter int MSG_LEN      = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      success,
    input  logic [23:0]               secret_key,
    decoded_msg_uart_if.master        ram,
    output logic                      uart_tx,
    output logic                      busy,
    output logic                      done
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_HDR      = 4'd1;
    localparam logic [3:0] S_RD_ADDR  = 4'd2;
    localparam logic [3:0] S_RD_WAIT  = 4'd3;
    localparam logic [3:0] S_TX_START = 4'd4;
    localparam logic [3:0] S_TX_DATA  = 4'd5;
    localparam logic [3:0] S_TX_STOP  = 4'd6;
    localparam logic [3:0] S_EOL      = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;

    localparam logic [1:0] K_MSG = 2'd0;
    localparam logic [1:0] K_HDR = 2'd1;
    localparam logic [1:0] K_EOL = 2'd2;

    localparam logic [15:0] CNT_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] CNT_PRE  = 16'(CLKS_PER_BIT - 2);
    localparam logic [4:0]  IDX_LAST = 5'(MSG_LEN - 1);

    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) hex_ascii = 8'h30 + {4'h0, nib};
        else             hex_ascii = 8'h37 + {4'h0, nib};
    endfunction

    function automatic logic [7:0] hdr_char(input logic [2:0] sel, input logic [23:0] key);
        case (sel)
            3'd0:    hdr_char = 8'h4B;
            3'd1:    hdr_char = hex_ascii(key[23:20]);
            3'd2:    hdr_char = hex_ascii(key[19:16]);
            3'd3:    hdr_char = hex_ascii(key[15:12]);
            3'd4:    hdr_char = hex_ascii(key[11:8]);
            3'd5:    hdr_char = hex_ascii(key[7:4]);
            3'd6:    hdr_char = hex_ascii(key[3:0]);
            default: hdr_char = 8'h3A;
        endcase
    endfunction

    logic [3:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [4:0]  idx_q, idx_d;
    logic [1:0]  kind_q, kind_d;
    logic [2:0]  sub_q, sub_d;
    logic [23:0] key_q, key_d;
    logic        wait_q, wait_d;
    logic        success_q, armed_q;
    logic        tx_q, tx_d, rden_q, rden_d, busy_q, busy_d, done_q, done_d;
    logic [4:0]  addr_q, addr_d;
    logic        start_s, bit_end_s;

    // A start needs success seen low since reset (armed) and then a fresh rising edge.
    assign start_s   = success && !success_q && armed_q &&
                       ((state_q == S_IDLE) || (state_q == S_DONE));
    assign bit_end_s = (cnt_q == CNT_LAST);

    // Next-state logic for the sequencer, the bit timer and the registered outputs.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        kind_d  = kind_q;
        sub_d   = sub_q;
        key_d   = key_q;
        wait_d  = wait_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_s) begin
                    key_d = secret_key;
                    idx_d = 5'd0;
                    cnt_d = 16'd0;
`ifdef KEY_HEADER_EN
                    state_d = S_HDR;
`else
                    state_d = S_RD_ADDR;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            S_HDR: begin
                kind_d  = K_HDR;
                sub_d   = 3'd0;
                shift_d = hdr_char(3'd0, key_q);
                cnt_d   = 16'd0;
                state_d = S_TX_START;
            end
            S_RD_ADDR: begin
                kind_d  = K_MSG;
                wait_d  = 1'b0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (wait_q) begin
                    shift_d = ram.ram_q;
                    cnt_d   = 16'd0;
                    state_d = S_TX_START;
                end else begin
                    wait_d = 1'b1;
                end
            end
            S_TX_START: begin
                if (bit_end_s) begin
                    cnt_d   = 16'd0;
                    bit_d   = 3'd0;
                    state_d = S_TX_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_TX_DATA: begin
                if (bit_end_s) begin
                    cnt_d   = 16'd0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = S_TX_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_TX_STOP: begin
                // EOL takes the last stop cycle of the final message byte so CR follows with no gap.
                if ((kind_q == K_MSG) && (idx_q == IDX_LAST) && (cnt_q == CNT_PRE)) begin
                    cnt_d   = 16'd0;
                    state_d = S_EOL;
                end else if (bit_end_s) begin
                    cnt_d = 16'd0;
                    case (kind_q)
                        K_MSG: begin
                            if (idx_q != IDX_LAST) begin
                                idx_d   = idx_q + 5'd1;
                                state_d = S_RD_ADDR;
                            end else begin
                                state_d = S_EOL;
                            end
                        end
                        K_HDR: begin
                            if (sub_q == 3'd7) begin
                                state_d = S_RD_ADDR;
                            end else begin
                                sub_d   = sub_q + 3'd1;
                                shift_d = hdr_char(sub_q + 3'd1, key_q);
                                state_d = S_TX_START;
                            end
                        end
                        K_EOL: begin
                            if (sub_q == 3'd0) begin
                                sub_d   = 3'd1;
                                shift_d = 8'h0A;
                                state_d = S_TX_START;
                            end else begin
                                state_d = S_DONE;
                            end
                        end
                        default: state_d = S_IDLE;
                    endcase
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_EOL: begin
                kind_d  = K_EOL;
                sub_d   = 3'd0;
                shift_d = 8'h0D;
                cnt_d   = 16'd0;
                state_d = S_TX_START;
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_TX_START: tx_d = 1'b0;
            S_TX_DATA:  tx_d = shift_d[0];
            default:    tx_d = 1'b1;
        endcase
        rden_d = (state_d == S_RD_ADDR);
        if (state_d == S_RD_ADDR) addr_d = idx_d;
        else                      addr_d = addr_q;
        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    // State, datapath and output registers with asynchronous reset to an idle line.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 16'd0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            idx_q     <= 5'd0;
            kind_q    <= K_MSG;
            sub_q     <= 3'd0;
            key_q     <= 24'd0;
            wait_q    <= 1'b0;
            success_q <= 1'b0;
            armed_q   <= 1'b0;
            tx_q      <= 1'b1;
            rden_q    <= 1'b0;
            addr_q    <= 5'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            idx_q     <= idx_d;
            kind_q    <= kind_d;
            sub_q     <= sub_d;
            key_q     <= key_d;
            wait_q    <= wait_d;
            success_q <= success;
            armed_q   <= armed_q | ~success;
            tx_q      <= tx_d;
            rden_q    <= rden_d;
            addr_q    <= addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign uart_tx         = tx_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign ram.ram_rden    = rden_q;
    assign ram.ram_address = addr_q;

endmodule

// File: tb/tb_decoded_msg_uart.sv
// Randomized bench: a line receiver and RAM model compare each transfer against
// the frame list expected from the key and RAM contents.
module tb_decoded_msg_uart;
    localparam int CPB   = 4;
    localparam int MLEN  = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        success = 1'b0;
    logic [23:0] secret_key = 24'd0;
    logic        uart_tx, busy, done;

    decoded_msg_uart_if ram_if ();

    decoded_msg_uart #(.CLKS_PER_BIT(CPB), .MSG_LEN(MLEN)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .success    (success),
        .secret_key (secret_key),
        .ram        (ram_if),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM with two cycles of read latency.
    logic [7:0] mem [32];
    logic [7:0] rd_d1;
    always @(posedge clk) begin
        if (ram_if.ram_rden) rd_d1 <= mem[ram_if.ram_address];
        ram_if.ram_q <= rd_d1;
    end

    typedef struct { logic [7:0] data; bit ok; int start; } frame_t;
    frame_t frames[$];
    int     rd_addrs[$];

    always @(negedge clk)
        if (reset_n && ram_if.ram_rden) rd_addrs.push_back(int'(ram_if.ram_address));

    // Line receiver: every bit must stay constant for CPB samples.
    initial begin : rx
        forever begin
            @(negedge clk);
            if (reset_n && uart_tx === 1'b0) begin
                frame_t     f;
                logic [9:0] bits;
                bit         ok;
                f.start = cyc;
                ok      = 1'b1;
                bits    = '0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (c == 0) bits[b] = uart_tx;
                        else if (uart_tx !== bits[b]) ok = 1'b0;
                    end
                end
                f.data = bits[8:1];
                f.ok   = ok && (bits[0] == 1'b0) && (bits[9] == 1'b1);
                frames.push_back(f);
            end
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic run_xfer(input logic [23:0] key, input bit glitch, input bit hold_high);
        logic [7:0] exp[$];
        int hdr_n, t, done_cyc, exp_gap;
        frames.delete();
        rd_addrs.delete();
        hdr_n = 0;
`ifdef KEY_HEADER_EN
        exp.push_back(8'h4B);
        for (int i = 0; i < 6; i++) begin
            int n;
            n = int'((key >> (20 - 4 * i)) & 24'hF);
            exp.push_back(n < 10 ? 8'(48 + n) : 8'(65 + n - 10));
        end
        exp.push_back(8'h3A);
        hdr_n = 8;
`endif
        for (int i = 0; i < MLEN; i++) exp.push_back(mem[i]);
        exp.push_back(8'h0D);
        exp.push_back(8'h0A);

        success = 1'b0;
        repeat (2) @(negedge clk);
        secret_key = key;
        success    = 1'b1;
        @(negedge clk);
        secret_key = 24'($urandom);
        check_eq("start_busy", 32'(busy), 32'd1);
        check_eq("start_done_clr", 32'(done), 32'd0);
        if (!hold_high) begin
            repeat ($urandom_range(1, 4)) @(negedge clk);
            success = 1'b0;
        end
        if (glitch) begin
            repeat ($urandom_range(30, 120)) @(negedge clk);
            success = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
            success = 1'b1;
            repeat ($urandom_range(1, 5)) @(negedge clk);
            if (!hold_high) success = 1'b0;
        end

        t = 0;
        while (done !== 1'b1 && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check_eq("done_seen", 32'(t < 5000), 32'd1);
        done_cyc = cyc;
        check_eq("busy_end", 32'(busy), 32'd0);
        check_eq("n_frames", frames.size(), exp.size());
        for (int i = 0; i < frames.size() && i < exp.size(); i++) begin
            check_eq($sformatf("frame%0d_data", i), 32'(frames[i].data), 32'(exp[i]));
            check_eq($sformatf("frame%0d_shape", i), 32'(frames[i].ok), 32'd1);
            if (i > 0) begin
                exp_gap = FRAME + ((i >= hdr_n && i < hdr_n + MLEN) ? 3 : 0);
                check_eq($sformatf("frame%0d_spacing", i), frames[i].start - frames[i-1].start, exp_gap);
            end
        end
        if (frames.size() > 0)
            check_eq("done_time", done_cyc, frames[frames.size()-1].start + FRAME);
        check_eq("n_rden", rd_addrs.size(), MLEN);
        for (int i = 0; i < rd_addrs.size() && i < MLEN; i++)
            check_eq($sformatf("rden%0d_addr", i), rd_addrs[i], i);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int t, lows, rdens;
        bit found;
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h43; mem[3] = 8'h44;

        repeat (3) @(negedge clk);
        check_eq("rst_tx", 32'(uart_tx), 32'd1);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_rden", 32'(ram_if.ram_rden), 32'd0);
        check_eq("rst_addr", 32'(ram_if.ram_address), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("idle_tx", 32'(uart_tx), 32'd1);

        // "ABCD" with a fixed key; success then stays high.
        run_xfer(24'h0003FA, 1'b0, 1'b1);
        frames.delete();
        rd_addrs.delete();
        repeat (1000) @(negedge clk);
        check_eq("hold_frames", frames.size(), 0);
        check_eq("hold_rden", rd_addrs.size(), 0);
        check_eq("hold_done", 32'(done), 32'd1);
        check_eq("hold_busy", 32'(busy), 32'd0);

        // Fresh pulse with mid-transfer success edges, then random transfers.
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        run_xfer(24'($urandom), 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
            run_xfer(24'($urandom), (k % 2) == 0, 1'b0);
        end

        // Reset in the middle of the data bits of byte 2 (all-zero byte).
        mem[2] = 8'h00;
        success = 1'b0;
        repeat (2) @(negedge clk);
        success = 1'b1;
        @(negedge clk);
        success = 1'b0;
        found = 1'b0;
        t = 0;
        while (!found && t < 3000) begin
            @(negedge clk);
            t++;
            found = ram_if.ram_rden && (ram_if.ram_address == 5'd2);
        end
        check_eq("byte2_read_seen", 32'(found), 32'd1);
        repeat (3 + CPB + 2 * CPB + 1) @(negedge clk);
        check_eq("pre_rst_tx_low", 32'(uart_tx), 32'd0);
        #2 reset_n = 1'b0;
        #1;
        check_eq("mid_rst_tx", 32'(uart_tx), 32'd1);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_rden", 32'(ram_if.ram_rden), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        lows = 0;
        rdens = 0;
        repeat (150) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
            if (ram_if.ram_rden !== 1'b0 || busy !== 1'b0 || done !== 1'b0) rdens++;
        end
        check_eq("post_rst_line_lows", lows, 0);
        check_eq("post_rst_activity", rdens, 0);

        // Success already high at reset release must not start a transfer.
        success = 1'b1;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        lows = 0;
        rdens = 0;
        repeat (200) begin
            @(negedge clk);
            if (uart_tx !== 1'b1) lows++;
            if (ram_if.ram_rden !== 1'b0 || busy !== 1'b0) rdens++;
        end
        check_eq("high_at_release_lows", lows, 0);
        check_eq("high_at_release_activity", rdens, 0);
        for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
        run_xfer(24'($urandom), 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
